ahb_arbiter: RTL and testbench

Round-robin AHB bus arbiter sharing one AHB-2 address/data bus between up to 15 `ahb_master` instances. It consumes per-master `o_hbusreq`/`o_hlock`, the muxed `htrans`, and slave `hready`/`hresp`/`hsplit`. It drives per-master `i_hgrant` plus the shared `i_hmaster`, which each master compares against its MASTER_ID, and `hmastlock`. It supports bus locking, SPLIT masking, a dummy master, and a per-tenure beat limit.

---
 rtl/ahb_arbiter.sv | 98 +++++++++
 tb/tb_ahb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB-2 bus arbiter with bus locking, SPLIT masking, dummy master and per-tenure beat limit
// Ports:
//   i_hclk, i_hreset_n        AHB clock, asynchronous active-low reset
//   i_hbusreq, i_hlock        per-master bus / lock request (bit i = master ID i+1)
//   i_hready, i_htrans        shared HREADY, muxed HTRANS of the address-phase owner
//   i_hresp, i_hsplit         shared HRESP, OR of slave HSPLITx (bit k = master ID k)
//   o_hgrant                  one-hot grant (bit i = master ID i+1), zero while the dummy master owns the bus
//   o_hmaster, o_hmastlock    address-phase owner ID and its lock flag
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 1,
    parameter int MAX_BEATS      = 16
) (
    input  logic                   i_hclk,
    input  logic                   i_hreset_n,
    input  logic [NUM_MASTERS-1:0] i_hbusreq,
    input  logic [NUM_MASTERS-1:0] i_hlock,
    input  logic                   i_hready,
    input  logic [1:0]             i_htrans,
    input  logic [1:0]             i_hresp,
    input  logic [15:0]            i_hsplit,
    output logic [NUM_MASTERS-1:0] o_hgrant,
    output logic [3:0]             o_hmaster,
    output logic                   o_hmastlock
);
    localparam logic [3:0] DEF_ID = 4'(DEFAULT_MASTER);
    localparam logic [4:0] NM5    = 5'(NUM_MASTERS);
    // Nine bits so that a limit of 256 beats is representable
    localparam logic [8:0] MAX_B  = 9'(MAX_BEATS);

    logic [3:0]             gnt_id_q, gnt_id_d, hmaster_q, hmaster_d;
    logic [3:0]             dp_master_q, dp_master_d, last_id_q, last_id_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
    logic [8:0]             beat_cnt_q, beat_cnt_d;
    logic [NUM_MASTERS-1:0] gnt_oh, set_vec, mask_eff, elig, rot;
    logic [4:0]             rr_off, rr_sum;
    logic [3:0]             rr_id, park_id, next_id;
    logic                   lock_hold, retain, unused_ok;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [3:0] id);
        return (id == 4'd0) ? '0 : NUM_MASTERS'(1) << (id - 4'd1);
    endfunction

    always_comb begin
        gnt_oh       = onehot(gnt_id_q);
        // A SPLIT completing this edge already excludes its master from this edge's decision
        set_vec      = (i_hresp == 2'd3 && i_hready && dp_master_q != 4'd0) ? onehot(dp_master_q) : '0;
        mask_eff     = split_mask_q | set_vec;
        elig         = i_hbusreq & ~mask_eff;
        // Bit j of rot is the eligibility of ID last_id+1+j, wrapped over 1..NUM_MASTERS
        rot          = NUM_MASTERS'({elig, elig} >> last_id_q);
        rr_off       = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) if (rot[k]) rr_off = 5'(k);
        rr_sum       = 5'(last_id_q) + rr_off + 5'd1;
        rr_id        = 4'((rr_sum > NM5) ? rr_sum - NM5 : rr_sum);
        lock_hold    = (gnt_id_q != 4'd0) && ((|(gnt_oh & i_hlock)) || hmastlock_q) && !(|(gnt_oh & mask_eff));
        retain       = (|(gnt_oh & elig)) && (beat_cnt_q < MAX_B);
        park_id      = (DEF_ID != 4'd0 && !(|(onehot(DEF_ID) & mask_eff))) ? DEF_ID : 4'd0;
        next_id      = (lock_hold || retain) ? gnt_id_q : (|elig) ? rr_id : park_id;
        gnt_id_d     = i_hready ? next_id : gnt_id_q;
        last_id_d    = (gnt_id_d != gnt_id_q && gnt_id_d != 4'd0) ? gnt_id_d : last_id_q;
        beat_cnt_d   = (gnt_id_d != gnt_id_q) ? 9'd0
                     : (i_hready && i_htrans[1] && hmaster_q == gnt_id_q && beat_cnt_q < MAX_B) ? beat_cnt_q + 9'd1
                     : beat_cnt_q;
        hmaster_d    = i_hready ? gnt_id_q : hmaster_q;
        dp_master_d  = i_hready ? hmaster_q : dp_master_q;
        hmastlock_d  = i_hready ? |(gnt_oh & i_hlock) : hmastlock_q;
        // Set wins over a same-cycle release
        split_mask_d = (split_mask_q & ~i_hsplit[NUM_MASTERS:1]) | set_vec;
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            gnt_id_q     <= DEF_ID;
            hmaster_q    <= DEF_ID;
            last_id_q    <= DEF_ID;
            dp_master_q  <= 4'd0;
            hmastlock_q  <= 1'b0;
            split_mask_q <= '0;
            beat_cnt_q   <= 9'd0;
        end else begin
            gnt_id_q     <= gnt_id_d;
            hmaster_q    <= hmaster_d;
            last_id_q    <= last_id_d;
            dp_master_q  <= dp_master_d;
            hmastlock_q  <= hmastlock_d;
            split_mask_q <= split_mask_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign o_hgrant    = gnt_oh;
    assign o_hmaster   = hmaster_q;
    assign o_hmastlock = hmastlock_q;
    // HSPLIT bit 0, bits above NUM_MASTERS and HTRANS[0] carry no arbitration meaning
    assign unused_ok   = ^{i_hsplit, i_htrans[0]};
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: self-checking bench for ahb_arbiter (4 masters, default master 1, 4-beat tenure)
module tb_ahb_arbiter;
    localparam int NM = 4, DEF = 1, MAXB = 4;

    logic        i_hclk = 1'b0, i_hreset_n = 1'b1;
    logic [3:0]  i_hbusreq = '0, i_hlock = '0;
    logic        i_hready = 1'b1;
    logic [1:0]  i_htrans = '0, i_hresp = '0;
    logic [15:0] i_hsplit = '0;
    logic [3:0]  o_hgrant, o_hmaster;
    logic        o_hmastlock;

    int n_pass = 0, n_chk = 0;
    int m_gnt, m_hm, m_dp, m_beat, m_last;
    bit m_lock;
    bit m_mask [0:15];

    typedef struct {
        logic [3:0]  req, lock;
        logic        rdy;
        logic [1:0]  trans, resp;
        logic [15:0] split;
        logic [3:0]  g, hm;
        logic        ml;
    } vec_t;
    vec_t tbl [15];

    ahb_arbiter #(.NUM_MASTERS(NM), .DEFAULT_MASTER(DEF), .MAX_BEATS(MAXB)) dut (
        .i_hclk(i_hclk), .i_hreset_n(i_hreset_n), .i_hbusreq(i_hbusreq), .i_hlock(i_hlock),
        .i_hready(i_hready), .i_htrans(i_htrans), .i_hresp(i_hresp), .i_hsplit(i_hsplit),
        .o_hgrant(o_hgrant), .o_hmaster(o_hmaster), .o_hmastlock(o_hmastlock)
    );

    always #5 i_hclk = ~i_hclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_gnt = DEF; m_hm = DEF; m_last = DEF; m_dp = 0; m_lock = 0; m_beat = 0;
        for (int i = 0; i < 16; i++) m_mask[i] = 0;
    endtask

    // Behavioural model: one bus edge, derived from the arbitration rules with plain integers
    task automatic model_edge();
        int  setid, ng, id;
        bit  el [0:15];
        bit  nlock;
        setid = (i_hresp == 2'd3 && i_hready && m_dp != 0) ? m_dp : 0;
        for (int i = 0; i < 16; i++)
            el[i] = (i >= 1 && i <= NM) ? (i_hbusreq[i-1] && !m_mask[i] && i != setid) : 1'b0;
        if (i_hready) begin
            ng = -1;
            if (m_gnt != 0 && (i_hlock[m_gnt-1] || m_lock) && !(m_mask[m_gnt] || m_gnt == setid)) ng = m_gnt;
            else if (el[m_gnt] && m_beat < MAXB) ng = m_gnt;
            else begin
                for (int k = 1; k <= NM; k++) begin
                    id = (m_last + k - 1) % NM + 1;
                    if (ng < 0 && el[id]) ng = id;
                end
                if (ng < 0) ng = (DEF != 0 && !(m_mask[DEF] || DEF == setid)) ? DEF : 0;
            end
            nlock = (m_gnt != 0) && i_hlock[m_gnt-1];
            if (ng != m_gnt) m_beat = 0;
            else if (i_htrans >= 2'd2 && m_hm == m_gnt && m_beat < MAXB) m_beat++;
            if (ng != m_gnt && ng != 0) m_last = ng;
            m_dp = m_hm; m_hm = m_gnt; m_lock = nlock; m_gnt = ng;
        end
        for (int k = 1; k <= NM; k++) if (i_hsplit[k]) m_mask[k] = 0;
        if (setid != 0) m_mask[setid] = 1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic rdy,
                         input logic [1:0] trans, input logic [1:0] resp, input logic [15:0] split);
        i_hbusreq = req; i_hlock = lock; i_hready = rdy; i_htrans = trans; i_hresp = resp; i_hsplit = split;
    endtask

    task automatic step(input string nm);
        logic [3:0] eg;
        model_edge();
        @(posedge i_hclk); #1;
        eg = (m_gnt == 0) ? 4'd0 : 4'(1 << (m_gnt - 1));
        chk({nm, ".model_gnt"}, 32'(o_hgrant), 32'(eg));
        chk({nm, ".model_hmaster"}, 32'(o_hmaster), 32'(m_hm));
        chk({nm, ".model_lock"}, 32'(o_hmastlock), 32'(m_lock));
    endtask

    task automatic expect_out(input string nm, input logic [3:0] g, input logic [3:0] hm, input logic ml);
        chk({nm, ".gnt"}, 32'(o_hgrant), 32'(g));
        chk({nm, ".hmaster"}, 32'(o_hmaster), 32'(hm));
        chk({nm, ".mastlock"}, 32'(o_hmastlock), 32'(ml));
    endtask

    // Asynchronous reset pulse away from the clock edge; outputs must return immediately
    task automatic async_reset(input string nm);
        #2 i_hreset_n = 1'b0;
        #1 expect_out(nm, 4'b0001, 4'd1, 1'b0);
        model_reset();
        @(negedge i_hclk);
        i_hreset_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{4'b0110, 4'b0000, 1'b1, 2'd0, 2'd0, 16'h0, 4'b0010, 4'd1, 1'b0};
        tbl[1]  = '{4'b0110, 4'b0000, 1'b1, 2'd0, 2'd0, 16'h0, 4'b0010, 4'd2, 1'b0};
        tbl[2]  = '{4'b0110, 4'b0000, 1'b1, 2'd2, 2'd0, 16'h0, 4'b0010, 4'd2, 1'b0};
        tbl[3]  = '{4'b0110, 4'b0000, 1'b1, 2'd3, 2'd0, 16'h0, 4'b0010, 4'd2, 1'b0};
        tbl[4]  = '{4'b0110, 4'b0000, 1'b1, 2'd3, 2'd0, 16'h0, 4'b0010, 4'd2, 1'b0};
        tbl[5]  = '{4'b0110, 4'b0000, 1'b1, 2'd3, 2'd0, 16'h0, 4'b0010, 4'd2, 1'b0};
        tbl[6]  = '{4'b0110, 4'b0000, 1'b1, 2'd0, 2'd0, 16'h0, 4'b0100, 4'd2, 1'b0};
        tbl[7]  = '{4'b0110, 4'b0000, 1'b1, 2'd0, 2'd0, 16'h0, 4'b0100, 4'd3, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 2'd0, 2'd0, 16'h0, 4'b0001, 4'd3, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 2'd0, 2'd0, 16'h0, 4'b0001, 4'd1, 1'b0};
        tbl[10] = '{4'b1000, 4'b1000, 1'b1, 2'd0, 2'd0, 16'h0, 4'b1000, 4'd1, 1'b0};
        tbl[11] = '{4'b1000, 4'b1000, 1'b1, 2'd0, 2'd0, 16'h0, 4'b1000, 4'd4, 1'b1};
        tbl[12] = '{4'b1001, 4'b0000, 1'b1, 2'd0, 2'd0, 16'h0, 4'b1000, 4'd4, 1'b0};
        tbl[13] = '{4'b1001, 4'b0000, 1'b1, 2'd0, 2'd0, 16'h0, 4'b1000, 4'd4, 1'b0};
        tbl[14] = '{4'b0001, 4'b0000, 1'b1, 2'd0, 2'd0, 16'h0, 4'b0001, 4'd4, 1'b0};

        async_reset("reset");
        for (int i = 0; i < 10; i++) begin
            step("idle");
            expect_out("idle", 4'b0001, 4'd1, 1'b0);
        end

        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].lock, tbl[i].rdy, tbl[i].trans, tbl[i].resp, tbl[i].split);
            step($sformatf("tbl%0d", i));
            expect_out($sformatf("tbl%0d", i), tbl[i].g, tbl[i].hm, tbl[i].ml);
        end

        // Lock holds the bus past the beat limit; release one edge after o_hmastlock falls
        async_reset("lock_rst");
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 4'b0001, 1'b1, 2'd2, 2'd0, 16'h0);
            step("lock");
            expect_out("lock", 4'b0001, 4'd1, 1'b1);
        end
        drive(4'b1111, 4'b0000, 1'b1, 2'd0, 2'd0, 16'h0);
        step("unlock1"); expect_out("unlock1", 4'b0001, 4'd1, 1'b0);
        step("unlock2"); expect_out("unlock2", 4'b0010, 4'd1, 1'b0);

        // SPLIT on master 3's data phase, then release via HSPLIT[3]
        async_reset("split_rst");
        drive(4'b0100, 4'b0, 1'b1, 2'd0, 2'd0, 16'h0); step("sp1"); expect_out("sp1", 4'b0100, 4'd1, 1'b0);
        step("sp2"); expect_out("sp2", 4'b0100, 4'd3, 1'b0);
        drive(4'b0110, 4'b0, 1'b1, 2'd2, 2'd0, 16'h0); step("sp3"); expect_out("sp3", 4'b0100, 4'd3, 1'b0);
        drive(4'b0110, 4'b0, 1'b0, 2'd0, 2'd3, 16'h0); step("sp4"); expect_out("sp4", 4'b0100, 4'd3, 1'b0);
        drive(4'b0110, 4'b0, 1'b1, 2'd0, 2'd3, 16'h0); step("sp5"); expect_out("sp5", 4'b0010, 4'd3, 1'b0);
        drive(4'b0100, 4'b0, 1'b1, 2'd0, 2'd0, 16'h0); step("sp6"); expect_out("sp6", 4'b0001, 4'd2, 1'b0);
        drive(4'b0100, 4'b0, 1'b1, 2'd0, 2'd0, 16'h8); step("sp7"); expect_out("sp7", 4'b0001, 4'd1, 1'b0);
        drive(4'b0100, 4'b0, 1'b1, 2'd0, 2'd0, 16'h0); step("sp8"); expect_out("sp8", 4'b0100, 4'd1, 1'b0);

        // Default master split-masked: park on dummy; same-cycle set and clear keeps the mask
        async_reset("dummy_rst");
        drive(4'b0001, 4'b0, 1'b1, 2'd2, 2'd0, 16'h0); step("dm1"); expect_out("dm1", 4'b0001, 4'd1, 1'b0);
        drive(4'b0001, 4'b0, 1'b1, 2'd0, 2'd3, 16'h2); step("dm2"); expect_out("dm2", 4'b0000, 4'd1, 1'b0);
        drive(4'b0001, 4'b0, 1'b1, 2'd0, 2'd0, 16'h0); step("dm3"); expect_out("dm3", 4'b0000, 4'd0, 1'b0);
        drive(4'b0001, 4'b0, 1'b1, 2'd0, 2'd0, 16'h2); step("dm4"); expect_out("dm4", 4'b0000, 4'd0, 1'b0);
        drive(4'b0001, 4'b0, 1'b1, 2'd0, 2'd0, 16'h0); step("dm5"); expect_out("dm5", 4'b0001, 4'd0, 1'b0);

        // Wait states freeze every stage
        for (int i = 0; i < 5; i++) begin
            drive(4'b1110, 4'b0, 1'b0, 2'd2, 2'd0, 16'h0);
            step("wait");
            expect_out("wait", 4'b0001, 4'd0, 1'b0);
        end
        drive(4'b1110, 4'b0, 1'b1, 2'd0, 2'd0, 16'h0); step("wait_end"); expect_out("wait_end", 4'b0010, 4'd1, 1'b0);

        // Randomized traffic against the model, with an asynchronous reset mid-run
        for (int i = 0; i < 600; i++) begin
            drive(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0,
                  $urandom_range(0, 9) != 0, 2'($urandom),
                  ($urandom_range(0, 7) == 0) ? 2'd3 : ($urandom_range(0, 5) == 0) ? 2'd1 : 2'd0,
                  ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0);
            step("rand");
            if (i == 300) async_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
